// File: rtl/calc_key_sequencer_if.sv
// Key-entry and Calculator-facing signal bundle for calc_key_sequencer.
// The master side drives keys and the Calculator result; the slave side is the sequencer.
interface calc_key_sequencer_if #(
    parameter int DW = 4,
    parameter int RW = 8
);
    logic          key_valid;
    logic [4:0]    key_code;
    logic          key_ready;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [1:0]    op;
    logic [RW-1:0] calc_result;
    logic [RW-1:0] result_q;
    logic          result_valid;
    logic          err;

    modport master (
        output key_valid, key_code, calc_result,
        input  key_ready, A, B, op, result_q, result_valid, err
    );

    modport slave (
        input  key_valid, key_code, calc_result,
        output key_ready, A, B, op, result_q, result_valid, err
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// Key-press front end for the 4-bit Calculator: builds A, op, B from keys, captures the
// result on '=', and raises a sticky error on operand overflow or divide-by-zero.
module calc_key_sequencer #(
    parameter int DW = 4,
    parameter int RW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    calc_key_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [4:0] K_EQ   = 5'h14;
    localparam logic [4:0] K_CLR  = 5'h15;
    localparam logic [7:0] OP_MAX = 8'((1 << DW) - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [RW-1:0] res_q, res_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic          b_seen_q, b_seen_d;
    logic          ready_q, ready_d;

    logic          accept;
    logic          key_digit;
    logic          key_op;
    logic          key_eq;
    logic          key_clr;
    logic [7:0]    acc_in;
    logic [7:0]    acc_sum;
    logic          acc_ovf;

    assign accept    = bus.key_valid & ready_q;
    assign key_digit = (bus.key_code < 5'd10);
    assign key_op    = (bus.key_code[4:2] == 3'b100);
    assign key_eq    = (bus.key_code == K_EQ);
    assign key_clr   = (bus.key_code == K_CLR);

    // Decimal accumulation of the operand currently being entered, evaluated at 8 bits
    assign acc_in  = (state_q == S_B) ? 8'(b_q) : 8'(a_q);
    assign acc_sum = (acc_in * 8'd10) + {3'b000, bus.key_code};
    assign acc_ovf = (acc_sum > OP_MAX);

    assign bus.key_ready    = ready_q;
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.op           = op_q;
    assign bus.result_q     = res_q;
    assign bus.result_valid = res_valid_q;
    assign bus.err          = err_q;

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'b00;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            b_seen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            b_seen_q    <= b_seen_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state and next-output decode for one accepted key per cycle
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        b_seen_d    = b_seen_q;

        if (accept && key_clr) begin
            state_d     = S_A;
            a_d         = '0;
            b_d         = '0;
            op_d        = 2'b00;
            res_d       = '0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
            b_seen_d    = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (accept && key_digit) begin
                        if (acc_ovf) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            a_d = acc_sum[DW-1:0];
                        end
                    end else if (accept && key_op) begin
                        op_d     = bus.key_code[1:0];
                        b_seen_d = 1'b0;
                        state_d  = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
                S_B: begin
                    if (accept && key_digit) begin
                        if (acc_ovf) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            b_d      = acc_sum[DW-1:0];
                            b_seen_d = 1'b1;
                        end
                    end else if (accept && key_op && !b_seen_q) begin
                        op_d = bus.key_code[1:0];
                    end else if (accept && key_eq) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_B;
                    end
                end
                S_EXEC: begin
                    if ((op_q == 2'b11) && (b_q == '0)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        res_d       = bus.calc_result;
                        res_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
                S_DONE: begin
                    // A fresh digit starts a new calculation and drops the old result flag
                    if (accept && key_digit) begin
                        a_d         = DW'(bus.key_code);
                        b_d         = '0;
                        op_d        = 2'b00;
                        res_valid_d = 1'b0;
                        b_seen_d    = 1'b0;
                        state_d     = S_A;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end

        ready_d = (state_d != S_EXEC);
    end
endmodule
